// File: rtl/count_checker_if.sv
// +----------------------------------------------------------------------+
// | count_checker_if                                                     |
// | Count-under-check inputs and checker status outputs, grouped.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

interface count_checker_if;
  logic [3:0]  count_in;
  logic        dir;
  logic        clear;
  logic        locked;
  logic        fault;
  logic        stall;
  logic [7:0]  err_cnt;
  logic [15:0] step_cnt;
  logic [3:0]  last_val;

  modport master (
    output count_in, dir, clear,
    input  locked, fault, stall, err_cnt, step_cnt, last_val
  );

  modport slave (
    input  count_in, dir, clear,
    output locked, fault, stall, err_cnt, step_cnt, last_val
  );
endinterface

`default_nettype wire

// File: rtl/count_checker.sv
// +----------------------------------------------------------------------+
// | count_checker                                                        |
// | Judges a 4-bit counter for +/-1 steps, tracks lock, errors, stalls.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module count_checker #(
  parameter int STALL_CYCLES = 67108864,
  parameter int LOCK_STEPS   = 2
) (
  input  logic          clk,
  input  logic          rst,
  count_checker_if.slave bus
);

  typedef enum logic [1:0] {
    ACQ   = 2'd0,
    SYNC  = 2'd1,
    TRACK = 2'd2
  } state_t;

  localparam logic [26:0] c_stall_max  = 27'(STALL_CYCLES);
  localparam logic [3:0]  c_lock_steps = 4'(LOCK_STEPS);

  state_t      r_state;
  logic [3:0]  r_s_cur;
  logic [3:0]  r_last_val;
  logic        r_dir_q;
  logic [3:0]  r_good;
  logic [26:0] r_timer;
  logic        r_locked;
  logic        r_fault;
  logic        r_stall;
  logic [7:0]  r_err_cnt;
  logic [15:0] r_step_cnt;

  logic        w_event;
  logic        w_valid;
  logic        w_dir_chg;
  logic        w_timer_hit;
  logic [3:0]  w_good_inc;
  logic [7:0]  w_err_base;
  logic [7:0]  w_err_inc;
  logic [15:0] w_step_base;

  assign w_event     = (r_s_cur != r_last_val);
  assign w_valid     = r_dir_q ? (r_s_cur == r_last_val - 4'd1)
                               : (r_s_cur == r_last_val + 4'd1);
  assign w_dir_chg   = (bus.dir != r_dir_q) && (r_state != ACQ);
  assign w_timer_hit = !w_event && (r_timer == c_stall_max - 27'd1);
  assign w_good_inc  = r_good + 4'd1;

  // A coincident clear acts first, so counters advance from zero.
  assign w_err_base  = bus.clear ? 8'd0 : r_err_cnt;
  assign w_err_inc   = (w_err_base == 8'hFF) ? 8'hFF : w_err_base + 8'd1;
  assign w_step_base = bus.clear ? 16'd0 : r_step_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ACQ;
      r_s_cur    <= '0;
      r_last_val <= '0;
      r_dir_q    <= 1'b0;
      r_good     <= '0;
      r_timer    <= '0;
      r_locked   <= 1'b0;
      r_fault    <= 1'b0;
      r_stall    <= 1'b0;
      r_err_cnt  <= '0;
      r_step_cnt <= '0;
    end else begin
      r_s_cur <= bus.count_in;
      r_dir_q <= bus.dir;

      if (w_event) begin
        r_last_val <= r_s_cur;
        r_timer    <= '0;
        r_stall    <= 1'b0;
      end else if (r_timer != c_stall_max) begin
        r_timer <= r_timer + 27'd1;
        r_stall <= (r_timer == c_stall_max - 27'd1);
      end

      if (bus.clear) begin
        r_fault    <= 1'b0;
        r_err_cnt  <= '0;
        r_step_cnt <= '0;
      end

      // A direction change resynchronises without judging the step.
      if (w_event && w_dir_chg) begin
        r_state  <= SYNC;
        r_good   <= '0;
        r_locked <= 1'b0;
      end else if (w_event) begin
        case (r_state)
          ACQ: begin
            r_state <= SYNC;
            r_good  <= '0;
          end
          SYNC: begin
            if (w_valid) begin
              r_good <= w_good_inc;
              if (w_good_inc == c_lock_steps) begin
                r_state  <= TRACK;
                r_locked <= 1'b1;
              end
            end else begin
              r_good <= '0;
            end
          end
          TRACK: begin
            if (w_valid) begin
              r_step_cnt <= w_step_base + 16'd1;
            end else begin
              r_err_cnt <= w_err_inc;
              r_fault   <= 1'b1;
              r_state   <= SYNC;
              r_good    <= '0;
              r_locked  <= 1'b0;
            end
          end
          default: begin
            r_state  <= ACQ;
            r_good   <= '0;
            r_locked <= 1'b0;
          end
        endcase
      end else if (w_timer_hit && (r_state != ACQ)) begin
        r_state  <= ACQ;
        r_good   <= '0;
        r_locked <= 1'b0;
      end else if (w_dir_chg) begin
        r_state  <= SYNC;
        r_good   <= '0;
        r_locked <= 1'b0;
      end
    end
  end

  assign bus.locked   = r_locked;
  assign bus.fault    = r_fault;
  assign bus.stall    = r_stall;
  assign bus.err_cnt  = r_err_cnt;
  assign bus.step_cnt = r_step_cnt;
  assign bus.last_val = r_last_val;

endmodule

`default_nettype wire

// File: tb/tb_count_checker.sv
// +----------------------------------------------------------------------+
// | tb_count_checker                                                     |
// | Directed vector table plus corner sequences for count_checker.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_count_checker;

  localparam int STALL = 16;
  localparam int LOCK  = 2;

  logic clk = 1'b0;
  logic rst;

  always #2.5 clk = ~clk;

  count_checker_if bus();

  count_checker #(
    .STALL_CYCLES(STALL),
    .LOCK_STEPS  (LOCK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit         do_rst;
    logic [3:0] cnt;
    bit         d;
    bit         clr;
    int         hold;
    bit         e_lock;
    bit         e_fault;
    bit         e_stall;
    int         e_err;
    int         e_step;
    int         e_last;
    int         e_state;
  } vec_t;

  int   n_vec  = 0;
  int   n_miss = 0;
  vec_t tbl[$];

  function automatic vec_t mk(input bit r, input int c, input bit d, input bit clr,
                              input int h, input bit l, input bit f, input bit s,
                              input int e, input int st, input int lv, input int stt);
    vec_t v;
    v.do_rst = r;   v.cnt = 4'(c);  v.d = d;        v.clr = clr;   v.hold = h;
    v.e_lock = l;   v.e_fault = f;  v.e_stall = s;  v.e_err = e;   v.e_step = st;
    v.e_last = lv;  v.e_state = stt;
    return v;
  endfunction

  task automatic cmp(input string tag, input string fld, input int act, input int exp);
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s %s: got %0d expected %0d", tag, fld, act, exp);
    end
  endtask

  task automatic check(input string tag, input vec_t v);
    n_vec++;
    cmp(tag, "locked",   int'(bus.locked),   int'(v.e_lock));
    cmp(tag, "fault",    int'(bus.fault),    int'(v.e_fault));
    cmp(tag, "stall",    int'(bus.stall),    int'(v.e_stall));
    cmp(tag, "err_cnt",  int'(bus.err_cnt),  v.e_err);
    cmp(tag, "step_cnt", int'(bus.step_cnt), v.e_step);
    cmp(tag, "last_val", int'(bus.last_val), v.e_last);
    cmp(tag, "state",    int'(dut.r_state),  v.e_state);
  endtask

  // Called at a falling edge; hold counts rising edges before the check.
  task automatic run(input string tag, input vec_t v, input bit do_chk);
    if (v.do_rst) begin
      rst          = 1'b0;
      bus.count_in = 4'd0;
      bus.dir      = 1'b0;
      bus.clear    = 1'b0;
      #1;
      if (do_chk) check(tag, v);
      @(negedge clk);
      rst = 1'b1;
    end else begin
      bus.count_in = v.cnt;
      bus.dir      = v.d;
      bus.clear    = v.clr;
      @(posedge clk);
      @(negedge clk);
      bus.clear = 1'b0;
      repeat (v.hold - 1) @(negedge clk);
      if (do_chk) check(tag, v);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cur;
    int nerr;

    rst          = 1'b0;
    bus.count_in = 4'd0;
    bus.dir      = 1'b0;
    bus.clear    = 1'b0;

    //         rst cnt d clr h   lk f st err step last state
    tbl.push_back(mk(1,  0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0));
    tbl.push_back(mk(0,  0, 0, 0, 4,  0, 0, 0, 0, 0,  0, 0));
    tbl.push_back(mk(0,  1, 0, 0, 4,  0, 0, 0, 0, 0,  1, 1));
    tbl.push_back(mk(0,  2, 0, 0, 4,  0, 0, 0, 0, 0,  2, 1));
    tbl.push_back(mk(0,  3, 0, 0, 4,  1, 0, 0, 0, 0,  3, 2));
    tbl.push_back(mk(0,  4, 0, 0, 4,  1, 0, 0, 0, 1,  4, 2));
    tbl.push_back(mk(1,  0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0));
    tbl.push_back(mk(0, 12, 0, 0, 4,  0, 0, 0, 0, 0, 12, 1));
    tbl.push_back(mk(0, 13, 0, 0, 4,  0, 0, 0, 0, 0, 13, 1));
    tbl.push_back(mk(0, 14, 0, 0, 4,  1, 0, 0, 0, 0, 14, 2));
    tbl.push_back(mk(0, 15, 0, 0, 4,  1, 0, 0, 0, 1, 15, 2));
    tbl.push_back(mk(0,  0, 0, 0, 4,  1, 0, 0, 0, 2,  0, 2));
    tbl.push_back(mk(0,  1, 0, 0, 4,  1, 0, 0, 0, 3,  1, 2));
    tbl.push_back(mk(0,  2, 0, 0, 4,  1, 0, 0, 0, 4,  2, 2));
    tbl.push_back(mk(0,  3, 0, 0, 4,  1, 0, 0, 0, 5,  3, 2));
    tbl.push_back(mk(0,  4, 0, 0, 4,  1, 0, 0, 0, 6,  4, 2));
    tbl.push_back(mk(0,  5, 0, 0, 4,  1, 0, 0, 0, 7,  5, 2));
    tbl.push_back(mk(0,  9, 0, 0, 4,  0, 1, 0, 1, 7,  9, 1));
    tbl.push_back(mk(0, 10, 0, 0, 4,  0, 1, 0, 1, 7, 10, 1));
    tbl.push_back(mk(0, 11, 0, 0, 4,  1, 1, 0, 1, 7, 11, 2));
    tbl.push_back(mk(0, 11, 0, 1, 4,  1, 0, 0, 0, 0, 11, 2));
    tbl.push_back(mk(0, 11, 0, 0, 9,  1, 0, 0, 0, 0, 11, 2));
    tbl.push_back(mk(0, 11, 0, 0, 1,  0, 0, 1, 0, 0, 11, 0));
    tbl.push_back(mk(0, 11, 0, 0, 2,  0, 0, 1, 0, 0, 11, 0));
    tbl.push_back(mk(0, 12, 0, 0, 4,  0, 0, 0, 0, 0, 12, 1));
    tbl.push_back(mk(0, 13, 0, 0, 4,  0, 0, 0, 0, 0, 13, 1));
    tbl.push_back(mk(0, 14, 0, 0, 4,  1, 0, 0, 0, 0, 14, 2));
    tbl.push_back(mk(0, 14, 0, 0, 12, 1, 0, 0, 0, 0, 14, 2));
    tbl.push_back(mk(0, 15, 0, 0, 2,  1, 0, 0, 0, 1, 15, 2));
    tbl.push_back(mk(0, 15, 0, 0, 8,  1, 0, 0, 0, 1, 15, 2));
    tbl.push_back(mk(0, 15, 1, 0, 3,  0, 0, 0, 0, 1, 15, 1));
    tbl.push_back(mk(0,  6, 1, 0, 4,  0, 0, 0, 0, 1,  6, 1));
    tbl.push_back(mk(0,  5, 1, 0, 4,  0, 0, 0, 0, 1,  5, 1));
    tbl.push_back(mk(0,  4, 1, 0, 4,  1, 0, 0, 0, 1,  4, 2));
    tbl.push_back(mk(0,  3, 1, 0, 4,  1, 0, 0, 0, 2,  3, 2));
    tbl.push_back(mk(0,  2, 1, 0, 4,  1, 0, 0, 0, 3,  2, 2));
    tbl.push_back(mk(0,  1, 1, 0, 4,  1, 0, 0, 0, 4,  1, 2));
    tbl.push_back(mk(0,  0, 1, 0, 4,  1, 0, 0, 0, 5,  0, 2));
    tbl.push_back(mk(0, 15, 1, 0, 4,  1, 0, 0, 0, 6, 15, 2));

    repeat (3) @(negedge clk);
    for (int i = 0; i < tbl.size(); i++)
      run($sformatf("row%0d", i), tbl[i], 1'b1);

    // Repeated jump-then-resync rounds, each error landing in TRACK.
    cur  = 15;
    nerr = 0;
    for (int r = 1; r <= 300; r++) begin
      bit chk;
      chk  = (r == 1) || (r == 20) || (r == 254) || (r == 255) || (r == 256) || (r == 300);
      cur  = (cur + 5) % 16;
      nerr = (nerr < 255) ? nerr + 1 : 255;
      run($sformatf("sat%0d_bad", r), mk(0, cur, 1, 0, 2, 0, 1, 0, nerr, 6, cur, 1), chk);
      cur = (cur + 15) % 16;
      run($sformatf("sat%0d_g1", r), mk(0, cur, 1, 0, 2, 0, 1, 0, nerr, 6, cur, 1), 1'b0);
      cur = (cur + 15) % 16;
      run($sformatf("sat%0d_g2", r), mk(0, cur, 1, 0, 2, 1, 1, 0, nerr, 6, cur, 2), chk);
    end

    // Clear landing on the same edge as an invalid TRACK step.
    cur          = (cur + 5) % 16;
    bus.count_in = 4'(cur);
    @(posedge clk);
    @(negedge clk);
    bus.clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.clear = 1'b0;
    check("clr_bad", mk(0, cur, 1, 0, 0, 0, 1, 0, 1, 0, cur, 1));

    cur = (cur + 15) % 16;
    run("clr_g1", mk(0, cur, 1, 0, 2, 0, 1, 0, 1, 0, cur, 1), 1'b0);
    cur = (cur + 15) % 16;
    run("clr_g2", mk(0, cur, 1, 0, 2, 1, 1, 0, 1, 0, cur, 2), 1'b1);

    // Clear landing on the same edge as a valid TRACK step.
    cur          = (cur + 15) % 16;
    bus.count_in = 4'(cur);
    @(posedge clk);
    @(negedge clk);
    bus.clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.clear = 1'b0;
    check("clr_good", mk(0, cur, 1, 0, 0, 1, 0, 0, 0, 1, cur, 2));

    cur = (cur + 15) % 16;
    run("after_clr", mk(0, cur, 1, 0, 2, 1, 0, 0, 0, 2, cur, 2), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
